// File: rtl/lms_ctr_gpo.sv
// Avalon-MM general-purpose output port: data, atomic set/clear and self-timed pulse registers.
// All pulse bits drop together exactly max(PULSE_LEN,1) cycles after the latest pulse write.
module lms_ctr_gpo #(
   parameter int unsigned DATA_WIDTH      = 32'd8,
   parameter logic [31:0] RESET_VALUE     = 32'h0000_0000,
   parameter int unsigned CNT_WIDTH       = 32'd16,
   parameter int unsigned PULSE_LEN_RESET = 32'd16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  write,
   input  logic [31:0]           writedata,
   input  logic                  read,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  pulse_busy
);

   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_LEN   = 3'd2;
   localparam logic [2:0] ADDR_SET   = 3'd4;
   localparam logic [2:0] ADDR_CLR   = 3'd5;
   localparam logic [2:0] ADDR_PULSE = 3'd6;

   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_RST  = RESET_VALUE[DATA_WIDTH-1:0];
   localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1'b1);
   localparam logic [CNT_WIDTH-1:0]  LEN_RST   = CNT_WIDTH'(PULSE_LEN_RESET);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t                  state_r, state_nxt_s;
   logic [DATA_WIDTH-1:0]   out_port_r, out_nxt_s;
   logic [DATA_WIDTH-1:0]   pmask_r, pmask_nxt_s;
   logic [CNT_WIDTH-1:0]    cnt_r, cnt_nxt_s;
   logic [CNT_WIDTH-1:0]    pulse_len_r, len_nxt_s;
   logic [31:0]             readdata_r, rd_nxt_s;
   logic                    busy_r;
   logic [DATA_WIDTH-1:0]   wd_s;
   logic [CNT_WIDTH-1:0]    load_s;
   logic                    pulse_start_s;
   logic                    unused_wd_s;

   assign wd_s          = writedata[DATA_WIDTH-1:0];
   assign unused_wd_s   = ^writedata;
   assign pulse_start_s = write && (address == ADDR_PULSE) && (wd_s != DATA_ZERO);
   // A zero length behaves as a one-cycle pulse.
   assign load_s        = (pulse_len_r == CNT_ZERO) ? CNT_ZERO : (pulse_len_r - CNT_ONE);

   assign readdata   = readdata_r;
   assign out_port   = out_port_r;
   assign pulse_busy = busy_r;

   // Register writes, pulse timing and read-data mux.
   always_comb begin
      out_nxt_s   = out_port_r;
      pmask_nxt_s = pmask_r;
      cnt_nxt_s   = cnt_r;
      len_nxt_s   = pulse_len_r;
      state_nxt_s = state_r;
      rd_nxt_s    = readdata_r;

      if (write) begin
         case (address)
            ADDR_DATA:  out_nxt_s = wd_s;
            ADDR_LEN:   len_nxt_s = writedata[CNT_WIDTH-1:0];
            ADDR_SET:   out_nxt_s = out_port_r | wd_s;
            ADDR_CLR:   out_nxt_s = out_port_r & ~wd_s;
            ADDR_PULSE: begin
               out_nxt_s   = out_port_r | wd_s;
               pmask_nxt_s = pmask_r | wd_s;
            end
            default:    out_nxt_s = out_port_r;
         endcase
      end else begin
         out_nxt_s = out_port_r;
      end

      // Restart beats terminal count; otherwise the terminal clear overrides same-edge writes.
      case (state_r)
         ST_IDLE: begin
            if (pulse_start_s) begin
               cnt_nxt_s   = load_s;
               state_nxt_s = ST_ACTIVE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (pulse_start_s) begin
               cnt_nxt_s = load_s;
            end else if (cnt_r == CNT_ZERO) begin
               out_nxt_s   = out_nxt_s & ~pmask_nxt_s;
               pmask_nxt_s = DATA_ZERO;
               state_nxt_s = ST_IDLE;
            end else begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase

      if (read && !write) begin
         rd_nxt_s = 32'h0000_0000;
         case (address)
            ADDR_DATA:  rd_nxt_s[DATA_WIDTH-1:0] = out_port_r;
            ADDR_LEN:   rd_nxt_s[CNT_WIDTH-1:0]  = pulse_len_r;
            ADDR_PULSE: rd_nxt_s[1:0]            = {busy_r, |pmask_r};
            default:    rd_nxt_s                 = 32'h0000_0000;
         endcase
      end else begin
         rd_nxt_s = readdata_r;
      end
   end

   // State register with synchronous reset; reset aborts any pulse in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         out_port_r  <= DATA_RST;
         pmask_r     <= DATA_ZERO;
         cnt_r       <= CNT_ZERO;
         pulse_len_r <= LEN_RST;
         readdata_r  <= 32'h0000_0000;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         out_port_r  <= out_nxt_s;
         pmask_r     <= pmask_nxt_s;
         cnt_r       <= cnt_nxt_s;
         pulse_len_r <= len_nxt_s;
         readdata_r  <= rd_nxt_s;
         busy_r      <= (state_nxt_s == ST_ACTIVE);
      end
   end

endmodule
